// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter in front of one waitrequest-style slave
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        bus_error
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t        state, state_nx;
    logic          last_grant, last_grant_nx;
    logic [CW-1:0] count, count_nx;
    logic          req0, req1, sel0, sel1, strobe, done, timeout;

    // state, most recent owner, watchdog count and the sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= '0;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            count      <= count_nx;
            bus_error  <= bus_error | timeout;
        end
    end

    // arbitration, completion/abort/timeout detection and watchdog counting
    always_comb begin
        req0          = m0_read | m0_write;
        req1          = m1_read | m1_write;
        sel0          = state == GNT0;
        sel1          = state == GNT1;
        strobe        = sel0 ? req0 : sel1 ? req1 : 1'b0;
        done          = strobe && !s_waitrequest;
        timeout       = (TIMEOUT_CYCLES > 0) && (sel0 || sel1) && s_waitrequest
                        && (count == CW'(TIMEOUT_CYCLES));
        state_nx      = state;
        last_grant_nx = last_grant;
        count_nx      = '0;
        if (state == IDLE) begin
            if (req0 && (!req1 || last_grant)) begin
                state_nx      = GNT0;
                last_grant_nx = 1'b0;
                count_nx      = CW'(1);
            end else if (req1) begin
                state_nx      = GNT1;
                last_grant_nx = 1'b1;
                count_nx      = CW'(1);
            end
        end else if (timeout || done || !strobe) begin
            state_nx = IDLE;
        end else begin
            count_nx = count + 1'b1;
        end
    end

    // route the owner's request to the slave and the slave's response back
    always_comb begin
        grant          = {sel1, sel0};
        s_address      = sel0 ? m0_address    : sel1 ? m1_address    : '0;
        s_writedata    = sel0 ? m0_writedata  : sel1 ? m1_writedata  : '0;
        s_byteenable   = sel0 ? m0_byteenable : sel1 ? m1_byteenable : '0;
        s_read         = !timeout && (sel0 ? m0_read  : sel1 ? m1_read  : 1'b0);
        s_write        = !timeout && (sel0 ? m0_write : sel1 ? m1_write : 1'b0);
        m0_waitrequest = sel0 ? (s_waitrequest && !timeout) : 1'b1;
        m1_waitrequest = sel1 ? (s_waitrequest && !timeout) : 1'b1;
        m0_readdata    = (sel0 && timeout) ? 32'hDEADBEEF : s_readdata;
        m1_readdata    = (sel1 && timeout) ? 32'hDEADBEEF : s_readdata;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with a functional slave model
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        bus_error;

    logic        stall_fixed = 1'b0, rand_stall = 1'b0, rand_w = 1'b0, use_fixed = 1'b0;
    logic [31:0] fixed_rd = '0;
    int          run = 0;
    int          tests = 0, fails = 0;
    logic [32:0] exp0[$], exp1[$];

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // slave model: data is a fixed function of address; stalls scripted or random (at most 3 in a row)
    assign s_waitrequest = rand_stall ? rand_w : stall_fixed;
    assign s_readdata    = use_fixed ? fixed_rd : mem_val(s_address);

    always @(posedge clk) begin
        #1;
        rand_w = (run < 3) && ($urandom_range(0, 1) == 1);
        run = rand_w ? run + 1 : 0;
    end

    function automatic void retire(int n, logic rd, logic [31:0] data);
        logic [32:0] e;
        int sz = (n == 0) ? exp0.size() : exp1.size();
        check($sformatf("m%0d_pending", n), 72'(sz > 0), 72'(1));
        if (sz == 0) return;
        e = (n == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("m%0d_kind", n), 72'(rd), 72'(e[32]));
        if (rd) check($sformatf("m%0d_readdata", n), 72'(data), 72'(e[31:0]));
    endfunction

    // monitor: retire completions against the scoreboard and check forwarding to the slave
    always @(negedge clk) begin
        if (!reset) begin
            if ((m0_read | m0_write) && !m0_waitrequest) retire(0, m0_read, m0_readdata);
            if ((m1_read | m1_write) && !m1_waitrequest) retire(1, m1_read, m1_readdata);
            if (s_read | s_write) begin
                if (grant == 2'b01)
                    check("fwd_m0", {s_address, s_writedata, s_byteenable, s_read, s_write, 2'b0},
                          {m0_address, m0_writedata, m0_byteenable, m0_read, m0_write, 2'b0});
                else if (grant == 2'b10)
                    check("fwd_m1", {s_address, s_writedata, s_byteenable, s_read, s_write, 2'b0},
                          {m1_address, m1_writedata, m1_byteenable, m1_read, m1_write, 2'b0});
                else
                    check("fwd_grant", 72'(grant), 72'(1));
            end
            if (grant != 2'b01) check("m0_wait_not_owner", 72'(m0_waitrequest), 72'(1));
            if (grant != 2'b10) check("m1_wait_not_owner", 72'(m1_waitrequest), 72'(1));
        end
    end

    task automatic m_xfer(input int n, input logic [31:0] a, input logic rd,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] er);
        int guard = 0;
        if (n == 0) begin
            exp0.push_back({rd, rd ? er : 32'h0});
            m0_address = a; m0_writedata = wd; m0_byteenable = be; m0_read = rd; m0_write = !rd;
        end else begin
            exp1.push_back({rd, rd ? er : 32'h0});
            m1_address = a; m1_writedata = wd; m1_byteenable = be; m1_read = rd; m1_write = !rd;
        end
        do begin
            @(negedge clk);
            guard++;
        end while ((n == 0 ? m0_waitrequest : m1_waitrequest) && guard < 60);
        check($sformatf("m%0d_done_in_time", n), 72'(n == 0 ? m0_waitrequest : m1_waitrequest), 72'(0));
        @(posedge clk);
        #1;
        if (n == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else begin m1_read = 1'b0; m1_write = 1'b0; end
    endtask

    task automatic rand_master(input int n);
        logic [31:0] a;
        repeat (40) begin
            a = $urandom & 32'hFFFF_FFFC;
            m_xfer(n, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), mem_val(a));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        check("q0_drained", 72'(exp0.size()), 72'(0));
        check("q1_drained", 72'(exp1.size()), 72'(0));
        reset = 1'b1;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation did not finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [1:0] seq [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        // reset with m0 already requesting
        m0_read = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_grant", 72'(grant), 72'(0));
            check("rst_m0_wait", 72'(m0_waitrequest), 72'(1));
            check("rst_s_read", 72'(s_read), 72'(0));
            check("rst_bus_error", 72'(bus_error), 72'(0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        exp0.push_back({1'b1, mem_val(32'h0)});
        @(negedge clk);
        check("post_rst_grant", 72'(grant), 72'(0));
        check("post_rst_m0_wait", 72'(m0_waitrequest), 72'(1));
        check("post_rst_s_read", 72'(s_read), 72'(0));
        @(negedge clk);
        check("post_rst_grant2", 72'(grant), 72'(1));
        @(posedge clk);
        #1 m0_read = 1'b0;
        // single read with two stall cycles
        stall_fixed = 1'b1; use_fixed = 1'b1; fixed_rd = 32'h2402_0005;
        fork
            m_xfer(0, 32'hBFC0_0000, 1'b1, '0, 4'hF, 32'h2402_0005);
            begin
                @(negedge clk);
                check("sr_idle_grant", 72'(grant), 72'(0));
                repeat (2) begin
                    @(negedge clk);
                    check("sr_grant", 72'(grant), 72'(1));
                    check("sr_s_address", 72'(s_address), 72'(32'hBFC0_0000));
                    check("sr_m0_wait", 72'(m0_waitrequest), 72'(1));
                end
                @(posedge clk);
                #1 stall_fixed = 1'b0;
                @(negedge clk);
                check("sr_done_wait", 72'(m0_waitrequest), 72'(0));
                check("sr_readdata", 72'(m0_readdata), 72'(32'h2402_0005));
                @(negedge clk);
                check("sr_after_grant", 72'(grant), 72'(0));
            end
        join
        @(posedge clk);
        #1 use_fixed = 1'b0;
        // masked write from m1
        fork
            m_xfer(1, 32'h0000_0010, 1'b0, 32'hAABB_CCDD, 4'b0011, '0);
            begin
                @(negedge clk);
                check("mw_idle_m0_wait", 72'(m0_waitrequest), 72'(1));
                @(negedge clk);
                check("mw_grant", 72'(grant), 72'(2));
                check("mw_s_strobes", 72'({s_read, s_write}), 72'(1));
                check("mw_s_address", 72'(s_address), 72'(32'h10));
                check("mw_s_writedata", 72'(s_writedata), 72'(32'hAABB_CCDD));
                check("mw_s_byteenable", 72'(s_byteenable), 72'(4'b0011));
                check("mw_m0_wait", 72'(m0_waitrequest), 72'(1));
            end
        join
        @(posedge clk);
        #1;
        // m0 granted (m1 was last owner), then aborts while stalled; m1 waits
        stall_fixed = 1'b1;
        m0_address = 32'h100; m0_read = 1'b1;
        m1_address = 32'h80; m1_byteenable = 4'hF; m1_read = 1'b1;
        exp1.push_back({1'b1, mem_val(32'h80)});
        @(negedge clk);
        check("ab_idle_grant", 72'(grant), 72'(0));
        @(negedge clk);
        check("ab_grant0", 72'(grant), 72'(1));
        @(posedge clk);
        #1 m0_read = 1'b0;
        @(negedge clk);
        check("ab_drop_grant", 72'(grant), 72'(1));
        @(posedge clk);
        #1 stall_fixed = 1'b0;
        @(negedge clk);
        check("ab_bubble_grant", 72'(grant), 72'(0));
        check("ab_bus_error", 72'(bus_error), 72'(0));
        @(negedge clk);
        check("ab_grant1", 72'(grant), 72'(2));
        check("ab_m1_wait", 72'(m1_waitrequest), 72'(0));
        @(posedge clk);
        #1 m1_read = 1'b0;
        // contention from reset, zero-wait slave
        do_reset();
        fork
            repeat (4) m_xfer(0, 32'h1000, 1'b1, '0, 4'hF, mem_val(32'h1000));
            repeat (4) m_xfer(1, 32'h2000, 1'b1, '0, 4'hF, mem_val(32'h2000));
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check($sformatf("ct_grant_%0d", i), 72'(grant), 72'(seq[i]));
            end
        join
        @(posedge clk);
        #1;
        // randomized traffic on both masters with short random stalls
        rand_stall = 1'b1;
        fork
            rand_master(0);
            rand_master(1);
        join
        rand_stall = 1'b0;
        stall_fixed = 1'b1;
        check("rand_bus_error", 72'(bus_error), 72'(0));
        @(posedge clk);
        #1;
        // watchdog: slave stuck during an m1 read
        fork
            m_xfer(1, 32'h200, 1'b1, '0, 4'hF, 32'hDEAD_BEEF);
            begin
                @(negedge clk);
                check("wd_idle_grant", 72'(grant), 72'(0));
                for (int i = 1; i < 8; i++) begin
                    @(negedge clk);
                    check("wd_stall_wait", 72'(m1_waitrequest), 72'(1));
                end
                @(negedge clk);
                check("wd_to_wait", 72'(m1_waitrequest), 72'(0));
                check("wd_to_readdata", 72'(m1_readdata), 72'(32'hDEAD_BEEF));
                check("wd_to_s_read", 72'(s_read), 72'(0));
                check("wd_to_grant", 72'(grant), 72'(2));
                check("wd_to_err_not_yet", 72'(bus_error), 72'(0));
                @(negedge clk);
                check("wd_err_set", 72'(bus_error), 72'(1));
                check("wd_after_grant", 72'(grant), 72'(0));
            end
        join
        stall_fixed = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wd_err_sticky", 72'(bus_error), 72'(1));
        end
        @(posedge clk);
        #1 do_reset();
        @(negedge clk);
        check("final_bus_error", 72'(bus_error), 72'(0));
        check("final_grant", 72'(grant), 72'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter that shares the single bus memory between the CPU's instruction-fetch port (m0) and data port (m1). All ports use the same read/write/waitrequest/byteenable bus protocol as the memory. The block sits between the CPU and the memory, forwards one granted transaction at a time, and arbitrates round-robin. An optional watchdog releases a master when the slave stalls for too long.

## Interface
- TIMEOUT_CYCLES, 0, maximum number of granted cycles a transfer may stay stalled; 0 disables the watchdog.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  32  master byte address.
- m0_read, m0_write / m1_read, m1_write  in  1 each  master request strobes.
- m0_writedata / m1_writedata  in  32  master write data.
- m0_byteenable / m1_byteenable  in  4  master byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  stall to master.
- m0_readdata / m1_readdata  out  32  read data to master.
- s_address  out  32  address forwarded to the slave.
- s_read, s_write  out  1  strobes forwarded to the slave.
- s_writedata  out  32  write data forwarded to the slave.
- s_byteenable  out  4  byte lanes forwarded to the slave.
- s_waitrequest  in  1  stall from the slave.
- s_readdata  in  32  read data from the slave.
- grant  out  2  one-hot current owner: 2'b01 = m0, 2'b10 = m1, 2'b00 = idle.
- bus_error  out  1  sticky flag, set by a watchdog timeout.

## Operation
- A master requests when its read or write is 1. It holds address, writedata, byteenable and the strobe stable until its waitrequest is 0.
- A transfer completes in a cycle where the granted master's strobe is 1 and its waitrequest is 0.
- FSM states: IDLE, GNT0, GNT1. The registered last_grant bit records the most recent owner.
- **IDLE**
  - grant=00. Both master waitrequest outputs are 1.
  - s_read = s_write = 0; s_address, s_writedata and s_byteenable are 0.
  - Arbitration with one requester: that requester is granted.
  - Arbitration with both requesting: the master that is not last_grant is granted.
  - The next state is GNTn, and last_grant is set to n.
- **GNTn**
  - All mn_* bus signals pass combinationally to s_*.
  - mn_waitrequest = s_waitrequest. The other master's waitrequest is 1.
  - Both masters receive s_readdata.
  - On completion, the next state is IDLE. This gives one bubble cycle between transfers.
  - If the granted master drops its strobe without completing (protocol violation), the next state is IDLE and nothing else happens.
- **Watchdog**, only when TIMEOUT_CYCLES > 0
  - A counter of width $clog2(TIMEOUT_CYCLES+1) loads 1 on the first GNTn cycle and increments on each stalled cycle.
  - Timeout condition: counter == TIMEOUT_CYCLES and s_waitrequest == 1.
  - In the timeout cycle: mn_waitrequest is forced to 0, mn_readdata is forced to 32'hDEADBEEF, and s_read/s_write are forced to 0.
  - Also on timeout: bus_error is set to 1 and the next state is IDLE.
  - bus_error clears only on reset.
- The arbiter does not check read and write both being asserted; both strobes are forwarded unchanged.

## Timing
- Reset values:
  - state = IDLE and last_grant = m1, so m0 wins the first contention.
  - grant = 00, bus_error = 0, counter = 0.
  - Both master waitrequest outputs = 1; s_read = s_write = 0.
- A reset asserted mid-transfer takes effect at the next edge: s_read/s_write are low in the following cycle and any in-flight transfer is abandoned.
- Arbitration latency: a request is seen in IDLE at cycle t; the slave strobe is driven at t+1.
- Minimum occupancy is 2 cycles per transfer (1 grant cycle + 1 IDLE).
- Contention: two masters requesting continuously are served alternately, 01, 00, 10, 00, 01, and so on.
- Completion and timeout both take effect in the same cycle they are detected. grant is 00 in the next cycle.
- mn_readdata is valid only in the completion cycle of the master that owns the grant.

## Test plan
- **Reset:** reset=1 for 2 cycles, with m0_read=1 held -> during reset and the cycle after it: grant=00, m0_waitrequest=1, s_read=0, bus_error=0. grant=01 in the second cycle after reset releases.
- **Single read:** m0 reads 0xBFC00000; the slave holds waitrequest=1 for 2 cycles, then 0 with readdata 0x24020005 -> s_address=0xBFC00000 while granted. m0_waitrequest=0 and m0_readdata=0x24020005 in exactly that cycle. grant=00 in the next cycle.
- **Masked write:** m1 writes address 0x00000010, data 0xAABBCCDD, byteenable 4'b0011 -> the slave sees identical values with s_write=1. m0_waitrequest stays 1 throughout.
- **Contention fairness:** from reset, m0 and m1 both read continuously; the slave has zero wait -> the grant sequence is 01, 00, 10, 00, 01, 00, 10. Neither master is served twice in a row.
- **Watchdog:** TIMEOUT_CYCLES=8 and s_waitrequest stuck at 1 during an m1 read -> in the 8th GNT1 cycle: m1_waitrequest=0, m1_readdata=0xDEADBEEF, s_read=0. bus_error=1 from the next cycle until reset.
- **Aborted request:** m0 is granted, then drops m0_read while s_waitrequest=1 -> the next state is IDLE and bus_error stays 0. A pending m1 request is granted on the following cycle.
